// File: rtl/ryu_motion_ctrl.sv
// ryu_motion_ctrl
//   Converts the current USB HID keycode into Ryu's on-screen position and pose
//   code. All motion advances once per video frame, on the rising edge of VGA
//   vsync, and the outputs are registered for the sprite selector/ROM stage.
//
// Ports
//   vga_clk   in   1   pixel clock, sole clock
//   Reset     in   1   asynchronous, active-high reset
//   vs        in   1   VGA vertical sync
//   keycode   in   8   0x04 A (left), 0x07 D (right), 0x1A W (jump), 0x0D J (punch)
//   RyuX      out 10   sprite top-left X
//   RyuY      out 10   sprite top-left Y
//   sprite    out  3   pose code: 0 standing, 1 punching, 2 jumping
//   airborne  out  1   high while jumping
module ryu_motion_ctrl #(
  parameter int X_INIT       = 100,
  parameter int Y_GROUND     = 300,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 560,
  parameter int WALK_STEP    = 2,
  parameter int PUNCH_FRAMES = 12,
  parameter int JUMP_V0      = 12,
  parameter int GRAVITY      = 1
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic       vs,
  input  logic [7:0] keycode,
  output logic [9:0] RyuX,
  output logic [9:0] RyuY,
  output logic [2:0] sprite,
  output logic       airborne
);

  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_J = 8'h0D;

  localparam logic [1:0] ST_STAND = 2'd0;
  localparam logic [1:0] ST_PUNCH = 2'd1;
  localparam logic [1:0] ST_JUMP  = 2'd2;

  logic [1:0]         state;
  logic               vs_q;
  logic               tick;
  logic signed [7:0]  vel;
  logic [7:0]         punch_cnt;
  logic signed [11:0] y_next;
  logic [9:0]         x_walk;

  // Horizontal walk with clamping. The arithmetic is done signed and wider
  // than RyuX so a step left from near 0 goes negative instead of wrapping.
  function automatic logic [9:0] walk_x(input logic [9:0] x, input logic [7:0] key);
    logic signed [11:0] left;
    logic signed [11:0] right;
    left   = $signed({2'b00, x}) - $signed(12'(WALK_STEP));
    right  = $signed({2'b00, x}) + $signed(12'(WALK_STEP));
    walk_x = x;
    if (key == KEY_A) begin
      walk_x = (left < $signed(12'(X_MIN))) ? 10'(X_MIN) : left[9:0];
    end else if (key == KEY_D) begin
      walk_x = (right > $signed(12'(X_MAX))) ? 10'(X_MAX) : right[9:0];
    end
  endfunction

  always_comb begin
    // One-cycle frame tick on the 0->1 edge of vsync
    tick   = vs & ~vs_q;
    // Screen Y grows downward, so positive (upward) velocity reduces Y
    y_next = $signed({2'b00, RyuY}) - $signed({{4{vel[7]}}, vel});
    x_walk = walk_x(RyuX, keycode);
  end

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      vs_q      <= 1'b1;
      state     <= ST_STAND;
      RyuX      <= 10'(X_INIT);
      RyuY      <= 10'(Y_GROUND);
      sprite    <= 3'd0;
      airborne  <= 1'b0;
      vel       <= 8'sd0;
      punch_cnt <= 8'd0;
    end else begin
      vs_q <= vs;
      if (tick) begin
        case (state)
          ST_STAND: begin
            if (keycode == KEY_W) begin
              state    <= ST_JUMP;
              vel      <= 8'(JUMP_V0);
              sprite   <= 3'd2;
              airborne <= 1'b1;
            end else if (keycode == KEY_J) begin
              state     <= ST_PUNCH;
              punch_cnt <= 8'(PUNCH_FRAMES - 1);
              sprite    <= 3'd1;
            end else begin
              RyuX <= x_walk;
            end
          end
          ST_PUNCH: begin
            // Position frozen and keys ignored until the counter expires
            if (punch_cnt != 8'd0) begin
              punch_cnt <= punch_cnt - 8'd1;
            end else begin
              state  <= ST_STAND;
              sprite <= 3'd0;
            end
          end
          ST_JUMP: begin
            RyuX <= x_walk;
            if (y_next >= $signed(12'(Y_GROUND))) begin
              RyuY     <= 10'(Y_GROUND);
              vel      <= 8'sd0;
              state    <= ST_STAND;
              sprite   <= 3'd0;
              airborne <= 1'b0;
            end else begin
              RyuY <= y_next[9:0];
              vel  <= vel - $signed(8'(GRAVITY));
            end
          end
          default: begin
            state <= ST_STAND;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ryu_motion_ctrl.sv
module tb_ryu_motion_ctrl;

  logic       vga_clk = 1'b0;
  logic       Reset   = 1'b1;
  logic       vs      = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [9:0] RyuX;
  logic [9:0] RyuY;
  logic [2:0] sprite;
  logic       airborne;

  int passed = 0;
  int total  = 0;

  ryu_motion_ctrl dut (
    .vga_clk (vga_clk),
    .Reset   (Reset),
    .vs      (vs),
    .keycode (keycode),
    .RyuX    (RyuX),
    .RyuY    (RyuY),
    .sprite  (sprite),
    .airborne(airborne)
  );

  always #5 vga_clk = ~vga_clk;

  // Reference model: pose is 0 stand / 1 punch / 2 jump. Punch tracks frames
  // elapsed since entry; jump height is the closed-form ballistic sum over
  // the ticks elapsed since take-off.
  int m_x, m_y, m_pose, m_age;

  function automatic void model_reset();
    m_x = 100; m_y = 300; m_pose = 0; m_age = 0;
  endfunction

  function automatic int walk(input int x, input logic [7:0] key);
    if (key == 8'h04) return (x - 2 < 0) ? 0 : x - 2;
    if (key == 8'h07) return (x + 2 > 560) ? 560 : x + 2;
    return x;
  endfunction

  function automatic void model_step(input logic [7:0] key);
    int h;
    case (m_pose)
      0: begin
        if (key == 8'h1A)      begin m_pose = 2; m_age = 0; end
        else if (key == 8'h0D) begin m_pose = 1; m_age = 0; end
        else m_x = walk(m_x, key);
      end
      1: begin
        m_age++;
        if (m_age == 12) m_pose = 0;
      end
      default: begin
        m_age++;
        h = m_age * 12 - (m_age * (m_age - 1)) / 2;
        if (300 - h >= 300) begin m_y = 300; m_pose = 0; end
        else m_y = 300 - h;
        m_x = walk(m_x, key);
      end
    endcase
  endfunction

  function automatic logic [22:0] exp_vec();
    return {10'(m_x), 10'(m_y), 3'(m_pose), (m_pose == 2)};
  endfunction

  // One vsync pulse (low for lo cycles, then high) with key held throughout
  task automatic frame(input logic [7:0] key, input int lo = 2);
    keycode = key;
    @(negedge vga_clk) vs = 1'b0;
    repeat (lo) @(negedge vga_clk);
    vs = 1'b1;
    repeat (2) @(negedge vga_clk);
    model_step(key);
  endtask

  task automatic test_reset();
    Reset = 1'b1; vs = 1'b0; keycode = 8'h00;
    repeat (3) @(negedge vga_clk);
    Reset = 1'b0;
    model_reset();
    @(negedge vga_clk);
    total++;
    if ({RyuX, RyuY, sprite, airborne} !== {10'd100, 10'd300, 3'd0, 1'b0})
      $display("FAIL reset_state: got X=%0d Y=%0d spr=%0d air=%0d, want 100/300/0/0",
               RyuX, RyuY, sprite, airborne);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      frame(8'h00);
      total++;
      if ({RyuX, RyuY, sprite, airborne} !== {10'd100, 10'd300, 3'd0, 1'b0})
        $display("FAIL idle_frame%0d: got X=%0d Y=%0d spr=%0d air=%0d, want 100/300/0/0",
                 i, RyuX, RyuY, sprite, airborne);
      else passed++;
    end
  endtask

  task automatic test_walk();
    for (int i = 0; i < 10; i++) frame(8'h07);
    total++;
    if (RyuX !== 10'd120) $display("FAIL walk_right: got X=%0d, want 120", RyuX);
    else passed++;
    for (int i = 0; i < 70; i++) begin
      frame(8'h04);
      total++;
      if ({RyuX, RyuY, sprite, airborne} !== exp_vec())
        $display("FAIL walk_left%0d: got X=%0d Y=%0d spr=%0d, want X=%0d Y=%0d spr=%0d",
                 i, RyuX, RyuY, sprite, m_x, m_y, m_pose);
      else passed++;
    end
    total++;
    if (RyuX !== 10'd0) $display("FAIL left_clamp: got X=%0d, want 0", RyuX);
    else passed++;
  endtask

  task automatic test_punch();
    int x0;
    for (int i = 0; i < 5; i++) frame(8'h07);
    x0 = m_x;
    frame(8'h0D);
    total++;
    if ({RyuX, sprite} !== {10'(x0), 3'd1})
      $display("FAIL punch_entry: got X=%0d spr=%0d, want X=%0d spr=1", RyuX, sprite, x0);
    else passed++;
    for (int i = 1; i <= 13; i++) begin
      frame(8'h07);
      total++;
      if ({RyuX, RyuY, sprite, airborne} !== exp_vec())
        $display("FAIL punch_tick%0d: got X=%0d Y=%0d spr=%0d, want X=%0d Y=%0d spr=%0d",
                 i, RyuX, RyuY, sprite, m_x, m_y, m_pose);
      else passed++;
      if (i == 11 || i == 12) begin
        total++;
        if (sprite !== ((i == 11) ? 3'd1 : 3'd0) || RyuX !== 10'(x0))
          $display("FAIL punch_len%0d: got spr=%0d X=%0d, want spr=%0d X=%0d",
                   i, sprite, RyuX, (i == 11) ? 1 : 0, x0);
        else passed++;
      end
    end
  endtask

  task automatic test_jump();
    int x0;
    x0 = m_x;
    frame(8'h1A);
    total++;
    if ({RyuY, sprite, airborne} !== {10'd300, 3'd2, 1'b1})
      $display("FAIL jump_entry: got Y=%0d spr=%0d air=%0d, want 300/2/1", RyuY, sprite, airborne);
    else passed++;
    for (int k = 1; k <= 25; k++) begin
      frame(8'h07);
      total++;
      if ({RyuX, RyuY, sprite, airborne} !== exp_vec())
        $display("FAIL jump_tick%0d: got X=%0d Y=%0d spr=%0d air=%0d, want X=%0d Y=%0d spr=%0d",
                 k, RyuX, RyuY, sprite, airborne, m_x, m_y, m_pose);
      else passed++;
      if (k == 1 || k == 12 || k == 13 || k == 25) begin
        total++;
        if (RyuY !== ((k == 1) ? 10'd288 : (k == 25) ? 10'd300 : 10'd222) ||
            RyuX !== 10'(x0 + 2 * k))
          $display("FAIL jump_key%0d: got X=%0d Y=%0d, want X=%0d", k, RyuX, RyuY, x0 + 2 * k);
        else passed++;
      end
    end
    total++;
    if ({sprite, airborne} !== {3'd0, 1'b0})
      $display("FAIL jump_land: got spr=%0d air=%0d, want 0/0", sprite, airborne);
    else passed++;
  endtask

  task automatic test_async_reset();
    frame(8'h1A);
    for (int i = 0; i < 6; i++) frame(8'h00);
    total++;
    if (RyuY !== 10'd243) $display("FAIL midjump_y: got Y=%0d, want 243", RyuY);
    else passed++;
    @(negedge vga_clk);
    #2 Reset = 1'b1;
    #1;
    total++;
    if ({RyuX, RyuY, sprite, airborne} !== {10'd100, 10'd300, 3'd0, 1'b0})
      $display("FAIL async_reset: got X=%0d Y=%0d spr=%0d air=%0d, want 100/300/0/0",
               RyuX, RyuY, sprite, airborne);
    else passed++;
    model_reset();
    @(negedge vga_clk) Reset = 1'b0;
  endtask

  task automatic test_vs_static();
    frame(8'h00);
    keycode = 8'h07;
    vs = 1'b1;
    repeat (1000) @(negedge vga_clk);
    total++;
    if ({RyuX, RyuY, sprite, airborne} !== exp_vec())
      $display("FAIL vs_high_static: got X=%0d, want X=%0d", RyuX, m_x);
    else passed++;
    vs = 1'b0;
    repeat (1000) @(negedge vga_clk);
    total++;
    if ({RyuX, RyuY, sprite, airborne} !== exp_vec())
      $display("FAIL vs_low_static: got X=%0d, want X=%0d", RyuX, m_x);
    else passed++;
    vs = 1'b1;
    repeat (5) @(negedge vga_clk);
    model_step(8'h07);
    total++;
    if (RyuX !== 10'(m_x) || RyuX !== 10'd102)
      $display("FAIL single_edge: got X=%0d, want 102", RyuX);
    else passed++;
  endtask

  task automatic test_random();
    logic [7:0] keys [6];
    logic [7:0] k;
    keys[0] = 8'h00; keys[1] = 8'h04; keys[2] = 8'h07;
    keys[3] = 8'h1A; keys[4] = 8'h0D; keys[5] = 8'h55;
    for (int i = 0; i < 300; i++) begin
      k = keys[$urandom_range(5, 0)];
      frame(k, int'($urandom_range(4, 1)));
      total++;
      if ({RyuX, RyuY, sprite, airborne} !== exp_vec())
        $display("FAIL random%0d key=%h: got X=%0d Y=%0d spr=%0d air=%0d, want X=%0d Y=%0d spr=%0d",
                 i, k, RyuX, RyuY, sprite, airborne, m_x, m_y, m_pose);
      else passed++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_walk();
    test_punch();
    test_jump();
    test_async_reset();
    test_vs_static();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
